// File: rtl/uart_tx_frame.sv
// Self-timed UART transmit frame engine: start bit, DATA_W data bits LSB-first,
// optional parity, one or two stop bits, with an internal baud counter.
module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LOAD,
    input  logic [DATA_W-1:0] DATA,
    output logic              TX,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 2);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic parity_f(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end_s;

    // Next-state logic; TX/BUSY are derived from the next state so the outputs stay registered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_d     = par_q;
        bit_end_s = (cnt_q == CNT_LAST);
        cnt_d     = bit_end_s ? '0 : cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (LOAD) begin
                    state_d = S_START;
                    shift_d = DATA;
                    par_d   = parity_f(DATA, ODD_PAR);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        // DONE lands in the final clk of the last stop bit, one cycle before BUSY drops.
        done_d = (state_q == S_STOP) && (bit_q == STOP_LAST) && (cnt_q == CNT_PRE);
    end

    // Frame engine state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
